// File: rtl/npu_pkg.sv
// Shared NPU types and constants used by the output-buffer drain path.
package npu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    DRAIN    = 3'd2,
    FLUSH    = 3'd3,
    FINISH   = 3'd4
  } drain_state_e;

  localparam int OUT_BUF_RD_LATENCY = 1;
  // Enough bits to count every read that can be in flight inside the buffer.
  localparam int OUTSTANDING_W = $clog2(OUT_BUF_RD_LATENCY + 1);

endpackage

// File: rtl/drain_skid_fifo.sv
// Small synchronous skid FIFO with registered occupancy, count output and flush.
module drain_skid_fifo #(
  parameter int DATA_WIDTH = 128,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic                      push,
  input  logic [DATA_WIDTH-1:0]     push_data,
  input  logic                      pop,
  output logic                      out_valid,
  output logic [DATA_WIDTH-1:0]     out_data,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  do_pop;

  assign do_pop    = pop && (count_q != '0);
  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;
  assign count     = count_q;

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + CW'(push) - CW'(do_pop);
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && !do_pop && (count_q == CW'(DEPTH))));

endmodule

// File: rtl/output_drain_ctrl.sv
// Drains one completed output buffer onto a valid/ready stream toward the DMA.
// Optional OUTPUT_DRAIN_CHECKSUM_EN adds a 32-bit lane-sum checksum output.
module output_drain_ctrl
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [ADDR_WIDTH:0]     num_words,
  input  logic                    buffer_ready,
  output logic                    buf_rd_en,
  output logic [ADDR_WIDTH-1:0]   buf_rd_addr,
  input  logic [DATA_WIDTH-1:0]   buf_rd_data,
  input  logic                    buf_rd_valid,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_last,
  output logic                    busy,
  output logic                    done
`ifdef OUTPUT_DRAIN_CHECKSUM_EN
  ,
  output logic [31:0]             checksum
`endif
);

  localparam int CW  = ADDR_WIDTH + 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW  = FCW + 1;

  drain_state_e             state_q;
  logic [CW-1:0]            words_q;
  logic [CW-1:0]            issued_q;
  logic [CW-1:0]            sent_q;
  logic [OUTSTANDING_W-1:0] outstanding_q;
  logic                     done_q;
  logic [FCW-1:0]           fifo_count;
  logic                     credit_ok;
  logic                     push;
  logic                     pop;
  logic                     last_issue;
  logic                     last_beat;

  // Stream handshake: a beat transfers in any cycle with m_valid && m_ready;
  // m_valid never drops and m_data/m_last never change until that happens.
  assign pop  = m_valid && m_ready;
  // Returns with no read in flight (e.g. the one right after an abort) are dropped.
  assign push = buf_rd_valid && (outstanding_q != '0);

  assign credit_ok  = ({1'b0, fifo_count} + SW'(outstanding_q)) < SW'(FIFO_DEPTH);
  assign buf_rd_en  = (state_q == DRAIN) && (issued_q < words_q) && credit_ok;
  assign buf_rd_addr = issued_q[ADDR_WIDTH-1:0];
  assign last_issue = (issued_q == words_q - CW'(1));
  assign last_beat  = (sent_q == words_q - CW'(1));
  assign m_last     = m_valid && last_beat;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

  drain_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (abort),
    .push      (push),
    .push_data (buf_rd_data),
    .pop       (pop),
    .out_valid (m_valid),
    .out_data  (m_data),
    .count     (fifo_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      words_q       <= '0;
      issued_q      <= '0;
      sent_q        <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
    end else if (abort) begin
      state_q       <= IDLE;
      words_q       <= '0;
      issued_q      <= '0;
      sent_q        <= '0;
      outstanding_q <= '0;
      done_q        <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      outstanding_q <= outstanding_q + OUTSTANDING_W'(buf_rd_en) - OUTSTANDING_W'(push);
      if (pop) sent_q <= sent_q + CW'(1);
      case (state_q)
        IDLE: begin
          if (start) begin
            words_q  <= num_words;
            issued_q <= '0;
            sent_q   <= '0;
            state_q  <= WAIT_RDY;
          end
        end
        WAIT_RDY: begin
          if (buffer_ready) begin
            if (words_q == '0) begin
              state_q <= FINISH;
              done_q  <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (buf_rd_en) begin
            issued_q <= issued_q + CW'(1);
            if (last_issue) state_q <= FLUSH;
          end
        end
        FLUSH: begin
          // Leave on the final handshake itself so done lands the next cycle.
          if (pop && last_beat) begin
            state_q <= FINISH;
            done_q  <= 1'b1;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef OUTPUT_DRAIN_CHECKSUM_EN
  logic [31:0] lane_sum;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < DATA_WIDTH / 32; i++) begin
      lane_sum = lane_sum + m_data[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      checksum <= '0;
    end else if (start && !abort && (state_q == IDLE)) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum + lane_sum;
    end
  end
`endif

endmodule

// File: tb/tb_output_drain_ctrl.sv
// Self-checking bench for output_drain_ctrl with a buffer model and beat scoreboard.
module tb_output_drain_ctrl;

  localparam int DW   = 128;
  localparam int AW   = 12;
  localparam int FD   = 4;
  localparam int MEMN = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic [AW:0]   num_words;
  logic          buffer_ready;
  logic          buf_rd_en;
  logic [AW-1:0] buf_rd_addr;
  logic [DW-1:0] buf_rd_data;
  logic          buf_rd_valid;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic          done;
`ifdef OUTPUT_DRAIN_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  output_drain_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .num_words    (num_words),
    .buffer_ready (buffer_ready),
    .buf_rd_en    (buf_rd_en),
    .buf_rd_addr  (buf_rd_addr),
    .buf_rd_data  (buf_rd_data),
    .buf_rd_valid (buf_rd_valid),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .m_last       (m_last),
    .busy         (busy),
    .done         (done)
`ifdef OUTPUT_DRAIN_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- buffer read-port model (1-cycle latency) ----------------
  logic [DW-1:0] buf_mem [MEMN];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_rd_valid <= 1'b0;
      buf_rd_data  <= '0;
    end else begin
      buf_rd_valid <= buf_rd_en;
      buf_rd_data  <= buf_mem[buf_rd_addr[5:0]];
    end
  end

  // ---------------- consumer ready driver ----------------
  int ready_mode = 0;
  int ready_ph   = 0;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1: begin
        m_ready = ((ready_ph % 3) == 0);
        ready_ph++;
      end
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b1;
    endcase
  end

  // ---------------- scoreboard ----------------
  logic [DW:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [DW:0] got, input logic [DW:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  int          done_cnt = 0;
  int          done_cyc = 0;
  int          start_cyc = 0;
  int          last_hs_cyc = 0;
  int          first_hs_cyc = -1;
  int          first_rd_cyc = -1;
  int          first_val_cyc = -1;
  int          rd_cnt_run = 0;
  int          beats_run = 0;
  int          max_inflight = 0;
  bit          stall_pend = 1'b0;
  logic [DW:0] held;
  logic [DW:0] exp_beat;

  always @(negedge clk) begin
    if (rst_n) begin
      if ((rd_cnt_run - beats_run) > max_inflight) max_inflight = rd_cnt_run - beats_run;
      if (stall_pend) begin
        check_val("stall_valid", {{DW{1'b0}}, m_valid}, 1);
        check_val("stall_hold", {m_last, m_data}, held);
      end
      stall_pend = m_valid && !m_ready;
      held       = {m_last, m_data};
      if (buf_rd_en) begin
        check_val("rd_addr", {{(DW+1-AW){1'b0}}, buf_rd_addr}, rd_cnt_run);
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        rd_cnt_run++;
      end
      if (m_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (m_valid && m_ready) begin
        check_val("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          exp_beat = exp_q.pop_front();
          check_val("beat", {m_last, m_data}, exp_beat);
        end
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
        beats_run++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_mem();
    for (int i = 0; i < MEMN; i++) begin
      buf_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  task automatic start_drain(input int n);
    logic lastb;
    for (int i = 0; i < n; i++) begin
      lastb = (i == n - 1);
      exp_q.push_back({lastb, buf_mem[i]});
    end
    rd_cnt_run    = 0;
    beats_run     = 0;
    first_hs_cyc  = -1;
    first_rd_cyc  = -1;
    first_val_cyc = -1;
    max_inflight  = 0;
    num_words     = (AW+1)'(n);
    start         = 1'b1;
    start_cyc     = cyc;
    @(posedge clk); #1;
    start         = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n  = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("done_seen", done_cnt - d0, 1);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_drain_end(input string tag, input int n);
    check_val({tag, "_queue_empty"}, exp_q.size(), 0);
    check_val({tag, "_beats"}, beats_run, n);
    check_val({tag, "_reads"}, rd_cnt_run, n);
    check_val({tag, "_done_lat"}, done_cyc - last_hs_cyc, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0;
    int n;
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    num_words    = '0;
    buffer_ready = 1'b0;
    m_ready      = 1'b1;
    fill_mem();
    idle_cycles(3);
    check_val("rst_m_valid", {{DW{1'b0}}, m_valid}, 0);
    check_val("rst_m_data", {1'b0, m_data}, 0);
    check_val("rst_m_last", {{DW{1'b0}}, m_last}, 0);
    check_val("rst_rd_en", {{DW{1'b0}}, buf_rd_en}, 0);
    check_val("rst_rd_addr", {{(DW+1-AW){1'b0}}, buf_rd_addr}, 0);
    check_val("rst_busy", {{DW{1'b0}}, busy}, 0);
    check_val("rst_done", {{DW{1'b0}}, done}, 0);
`ifdef OUTPUT_DRAIN_CHECKSUM_EN
    check_val("rst_checksum", {97'd0, checksum}, 0);
`endif
    rst_n = 1'b1;
    idle_cycles(2);

    // Full-rate drain of 8 words.
    buffer_ready = 1'b1;
    start_drain(8);
    wait_done(100);
    check_drain_end("t1", 8);
    check_val("t1_throughput", last_hs_cyc - first_hs_cyc, 7);
    check_val("t1_first_latency", first_val_cyc - first_rd_cyc, 2);
    d0 = done_cnt;
    idle_cycles(3);
    check_val("t1_single_done", done_cnt - d0, 0);
    check_val("t1_idle", {{DW{1'b0}}, busy}, 0);

    // Backpressure 1,0,0 pattern.
    fill_mem();
    ready_ph   = 0;
    ready_mode = 1;
    start_drain(8);
    wait_done(300);
    check_drain_end("t2", 8);
    check_val("t2_fifo_bound", max_inflight <= FD, 1);
    ready_mode = 0;
    idle_cycles(2);

    // buffer_ready held low for 10 cycles after start.
    fill_mem();
    buffer_ready = 1'b0;
    start_drain(6);
    idle_cycles(10);
    check_val("t3_no_read_while_waiting", rd_cnt_run, 0);
    check_val("t3_busy_waiting", {{DW{1'b0}}, busy}, 1);
    buffer_ready = 1'b1;
    wait_done(100);
    check_drain_end("t3", 6);
    idle_cycles(2);

    // Zero-length drain.
    start_drain(0);
    wait_done(20);
    check_val("t4_done_cycle", done_cyc - start_cyc, 2);
    check_val("t4_no_reads", rd_cnt_run, 0);
    check_val("t4_no_valid", first_val_cyc, -1);
    idle_cycles(2);

    // Abort during word 3 of 16, then a clean 4-word drain.
    fill_mem();
    start_drain(16);
    n = 0;
    while (beats_run < 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_val("t5_reached_word3", beats_run >= 3, 1);
    d0    = done_cnt;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    exp_q.delete();
    check_val("t5_abort_idle", {{DW{1'b0}}, busy}, 0);
    check_val("t5_abort_no_valid", {{DW{1'b0}}, m_valid}, 0);
    idle_cycles(1);
    check_val("t5_late_return_dropped", {{DW{1'b0}}, m_valid}, 0);
    idle_cycles(4);
    check_val("t5_no_done", done_cnt - d0, 0);
    start_drain(4);
    wait_done(100);
    check_drain_end("t5b", 4);
    idle_cycles(2);

    // Random backpressure with random lengths.
    ready_mode = 2;
    for (int k = 0; k < 3; k++) begin
      fill_mem();
      n = $urandom_range(1, 20);
      start_drain(n);
      wait_done(500);
      check_drain_end("t6", n);
      check_val("t6_fifo_bound", max_inflight <= FD, 1);
      idle_cycles(2);
    end
    ready_mode = 0;
    idle_cycles(2);

`ifdef OUTPUT_DRAIN_CHECKSUM_EN
    buf_mem[0] = {(DW/32){32'h0000_0001}};
    buf_mem[1] = {(DW/32){32'h0000_0001}};
    start_drain(2);
    wait_done(100);
    check_drain_end("t7", 2);
    check_val("t7_checksum", {97'd0, checksum}, 2 * (DW / 32));
    idle_cycles(3);
    check_val("t7_checksum_hold", {97'd0, checksum}, 2 * (DW / 32));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
